// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, channel count and strobe helpers for the scan controller
package scan_pkg;
  localparam int NCH = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;
  localparam logic [NCH-1:0] AN_OFF = 4'b1111;
  function automatic logic [NCH-1:0] an_code(input logic [1:0] sel);
    return ~(NCH'(1) << sel);
  endfunction
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: scan control inputs and mux/display outputs of the scan controller
interface mux_scan_ctrl_if;
  import scan_pkg::*;
  logic run;
  logic [NCH-1:0] mask;
  logic [1:0] sel;
  logic mux_en;
  logic [NCH-1:0] an;
  logic tick;
  modport master(output run, mask, input sel, mux_en, an, tick);
  modport slave(input run, mask, output sel, mux_en, an, tick);
endinterface

// File: rtl/scan_prescaler.sv
// scan_prescaler: slot counter 0..DIV-1 with clear and last-cycle pulse
module scan_prescaler #(
  parameter int DIV = 50000,
  parameter int PW = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  output logic [PW-1:0] pcnt_o,
  output logic          last_o
);
  logic [PW-1:0] pcnt_q, pcnt_d;
  assign last_o = pcnt_q == PW'(DIV - 1);
  assign pcnt_d = (clr_i || last_o) ? '0 : pcnt_q + 1'b1;
  assign pcnt_o = pcnt_q;
  always_ff @(posedge clk) pcnt_q <= rst ? '0 : pcnt_d;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: rotating channel select and digit strobes; SCAN_BLANK_EN adds a settle-blank window per slot
module mux_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int BLANK = 16
) (
  input logic           clk,
  input logic           rst,
  mux_scan_ctrl_if.slave bus
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [PW-1:0] BL_LAST = PW'(BLANK - 1);
  localparam logic [1:0] ST_FIRST = (BLANK == 0) ? ST_SHOW : ST_BLANK;
`else
  localparam logic [1:0] ST_FIRST = ST_SHOW;
`endif
  if (DIV < 2 || BLANK >= DIV) begin : g_bad_cfg
    $error("mux_scan_ctrl: DIV must be >= 2 and BLANK < DIV");
  end
  logic [1:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic mux_en_q, tick_q, tick_d, show_d, last, clr;
  logic [NCH-1:0] an_q;
  logic [PW-1:0] pcnt;
  assign clr = !bus.run || state_q == ST_IDLE;
  scan_prescaler #(.DIV(DIV)) u_pre (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .pcnt_o(pcnt),
    .last_o(last)
  );
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    if (!bus.run) begin
      state_d = ST_IDLE;
      sel_d = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_FIRST;
    end else if (last) begin
      state_d = ST_FIRST;
      sel_d = sel_q + 2'd1;
`ifdef SCAN_BLANK_EN
    end else if (state_q == ST_BLANK && pcnt == BL_LAST) begin
      state_d = ST_SHOW;
`endif
    end
  end
  // outputs are registered from next state so sel and enable always move together
  assign show_d = state_d == ST_SHOW && !bus.mask[sel_d];
  assign tick_d = state_d != ST_IDLE && (state_q == ST_IDLE || pcnt == DIV_LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q <= '0;
      mux_en_q <= 1'b1;
      an_q <= AN_OFF;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      mux_en_q <= !show_d;
      an_q <= show_d ? an_code(sel_d) : AN_OFF;
      tick_q <= tick_d;
    end
  end
  assign bus.sel = sel_q;
  assign bus.mux_en = mux_en_q;
  assign bus.an = an_q;
  assign bus.tick = tick_q;
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential scan controller that sits directly upstream of the team's 4-way, 4-bit channel multiplexer. It rotates the 2-bit channel select through channels 0..3 at a programmable slot rate and drives the multiplexer's active-low enable. It also produces matching active-low one-hot digit strobes for a 4-digit multiplexed display. An optional blanking window at the start of each slot suppresses ghosting while select lines settle.

## Interface
- DIV, 50000: slot length in clk cycles; legal range DIV >= 2.
- BLANK, 16: blanked cycles at the start of each slot; legal range BLANK < DIV (used only with SCAN_BLANK_EN).
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- run  input  1  scanning enable; 0 forces idle.
- mask  input  4  per-channel disable; mask[i]=1 keeps channel i dark for its slot.
- sel  output  2  channel select to the multiplexer.
- mux_en  output  1  multiplexer enable, active-low: 0 passes the selected channel, 1 forces 4'b0000.
- an  output  4  digit strobes, active-low one-hot; an[i]=0 only while channel i is shown.
- tick  output  1  one-cycle pulse in the first cycle of every slot.

## Operation
- States: IDLE, BLANK, SHOW.
- Outputs in IDLE: sel=2'b00, mux_en=1, an=4'b1111, tick=0; prescaler held at 0.
- IDLE -> BLANK when run=1. The first slot always starts on channel 0.
- Prescaler pcnt counts 0..DIV-1 within each slot. Width is $clog2(DIV); it wraps to 0 at DIV-1.
- BLANK -> SHOW when pcnt reaches BLANK-1 (that is, after BLANK cycles).
- SHOW -> BLANK when pcnt = DIV-1. At the same time sel increments modulo 4, so 2'b11 wraps to 2'b00.
- Outputs in BLANK: mux_en=1, an=4'b1111.
- Outputs in SHOW with mask[sel]=0: mux_en=0, an=~(4'b0001<<sel).
- Outputs in SHOW with mask[sel]=1: mux_en=1, an=4'b1111. The slot still consumes DIV cycles, so refresh stays uniform.
- tick=1 in the cycle where pcnt=0 while not IDLE.
- run=0 in any state -> IDLE on the next edge. Counters and sel clear; a partial slot is discarded.
- mask changes take effect on the next cycle, including mid-slot.
- rst has priority over run.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values: sel=2'b00, mux_en=1, an=4'b1111, tick=0, state IDLE, pcnt=0.
- run rises and is sampled at edge N:
  - at N+1: state BLANK, pcnt=0, tick=1, sel=00;
  - first shown cycle: N+1+BLANK.
- Slot period is exactly DIV cycles. A full 4-channel frame is 4*DIV cycles.
- Channel change and blank start happen on the same edge. mux_en is never 0 with a stale sel.
- rst asserted mid-slot: reset values appear on the next edge, regardless of run.

## Configuration
- SCAN_BLANK_EN defined: BLANK state and parameter are active, as described above.
- SCAN_BLANK_EN undefined:
  - BLANK state is removed and the parameter is ignored;
  - slots go directly SHOW -> SHOW;
  - the first shown cycle is N+1;
  - mux_en and an change in the same cycle as sel.

## Structure
- Shared package scan_pkg:
  - state encoding constants ST_IDLE, ST_BLANK, ST_SHOW;
  - NCH=4;
  - AN_OFF=4'b1111.
- One sub-module, scan_prescaler: slot counter with clear input, pcnt output, and a last-cycle pulse.
- The FSM and output registers stay in mux_scan_ctrl.

## Test plan
Bench setting for all scenarios: DIV=8, BLANK=2, SCAN_BLANK_EN defined, unless stated otherwise.
- Reset check: rst=1 for 3 cycles with run=1 -> sel=00, mux_en=1, an=1111, tick=0 throughout and in the cycle after release if run=0.
- Normal rotation: run=1, mask=0000:
  - tick every 8 cycles;
  - per slot: 2 cycles with mux_en=1, an=1111, then 6 cycles with mux_en=0;
  - an sequence 1110, 1101, 1011, 0111;
  - sel wraps 11 -> 00 after 32 cycles.
- Masking: mask=0100 -> during the sel=10 slot, mux_en=1 and an=1111 for all 8 cycles; other slots unchanged; period still 32.
- Stop and restart: drop run during cycle 5 of the sel=01 slot -> IDLE outputs next cycle; reassert run -> restarts at sel=00 with tick=1.
- Reset mid-operation: rst pulsed for 1 cycle during SHOW with run=1 -> reset values next edge, then a restart from sel=00.
- No blanking: SCAN_BLANK_EN undefined -> mux_en=0 from the first slot cycle; an changes on the same edge as sel.
